// File: rtl/hazard_scoreboard_if.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_if
// Groups the decoder-side request, variable-latency writeback and stall/debug
// response signals of the hazard scoreboard.
//   id_*        : instruction currently in ID (sources, destination, latency)
//   wb_*        : writeback from the variable-latency unit (DIV)
//   stall_op    : hold ID and bubble EX
//   busy_vec_op : per-register pending-write flags
// Modports:
//   master : decoder / pipeline side, drives id_* and wb_*
//   slave  : scoreboard side, drives stall_op and busy_vec_op
// -----------------------------------------------------------------------------
interface hazard_scoreboard_if #(
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 4
);
  logic                  id_valid_ip;
  logic [REG_ADDR_W-1:0] id_rs1_ip;
  logic                  id_rs1_use_ip;
  logic [REG_ADDR_W-1:0] id_rs2_ip;
  logic                  id_rs2_use_ip;
  logic [REG_ADDR_W-1:0] id_rd_ip;
  logic                  id_rd_we_ip;
  logic [CNT_W-1:0]      id_lat_ip;
  logic                  wb_valid_ip;
  logic [REG_ADDR_W-1:0] wb_rd_ip;
  logic                  stall_op;
  logic [NUM_REGS-1:0]   busy_vec_op;

  modport master (
    output id_valid_ip, id_rs1_ip, id_rs1_use_ip, id_rs2_ip, id_rs2_use_ip,
           id_rd_ip, id_rd_we_ip, id_lat_ip, wb_valid_ip, wb_rd_ip,
    input  stall_op, busy_vec_op
  );

  modport slave (
    input  id_valid_ip, id_rs1_ip, id_rs1_use_ip, id_rs2_ip, id_rs2_use_ip,
           id_rd_ip, id_rd_we_ip, id_lat_ip, wb_valid_ip, wb_rd_ip,
    output stall_op, busy_vec_op
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Register scoreboard for the ID stage. Tracks every in-flight register write,
// either with a fixed countdown (ALU/load/MUL) or as a variable-latency entry
// that waits for a writeback (DIV), and stalls ID on RAW and WAW hazards.
// Ports:
//   clk   : core clock
//   reset : synchronous, active-high; clears all entries, forces stall_op low
//   sb    : hazard_scoreboard_if.slave (id_* request, wb_* writeback,
//           stall_op, busy_vec_op)
//   perf_stall_cnt_op : [31:0] saturating count of stall cycles
//                       (present only when SCOREBOARD_PERF_EN is defined)
// Optional feature macro: SCOREBOARD_PERF_EN
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = $clog2(NUM_REGS),
  parameter int MAX_LAT    = 8,
  parameter int CNT_W      = $clog2(MAX_LAT + 1)
) (
  input  logic               clk,
  input  logic               reset,
  hazard_scoreboard_if.slave sb
`ifdef SCOREBOARD_PERF_EN
  ,
  output logic [31:0]        perf_stall_cnt_op
`endif
);

  // Clamp a requested fixed latency to the longest countdown supported.
  function automatic logic [CNT_W-1:0] sat_lat(input logic [CNT_W-1:0] lat);
    if (lat > CNT_W'(MAX_LAT)) return CNT_W'(MAX_LAT);
    return lat;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) return v;
    return v + 32'd1;
  endfunction

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] is_var;
  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] ready;

  logic rs1_haz;
  logic rs2_haz;
  logic waw_haz;
  logic stall_raw;
  logic issue;

  // A source is ready if nothing is pending, or its producer completes
  // (countdown at 1, or matching writeback) in this very cycle.
  always_comb begin
    ready = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      ready[r] = !busy[r]
               || (!is_var[r] && (cnt[r] == CNT_W'(1)))
               || (is_var[r] && sb.wb_valid_ip && (sb.wb_rd_ip == REG_ADDR_W'(r)));
    end
  end

  assign rs1_haz = sb.id_rs1_use_ip && (sb.id_rs1_ip != '0) && !ready[sb.id_rs1_ip];
  assign rs2_haz = sb.id_rs2_use_ip && (sb.id_rs2_ip != '0) && !ready[sb.id_rs2_ip];
  // WAW looks at busy, not ready: a same-cycle completion still blocks the
  // new write so issue and retire never touch one entry on the same edge.
  assign waw_haz = sb.id_rd_we_ip && (sb.id_rd_ip != '0) && busy[sb.id_rd_ip];

  assign stall_raw = sb.id_valid_ip && (rs1_haz || rs2_haz || waw_haz);
  assign issue     = sb.id_valid_ip && !stall_raw && sb.id_rd_we_ip && (sb.id_rd_ip != '0);

  assign sb.stall_op    = !reset && stall_raw;
  assign sb.busy_vec_op = busy;

  // Entry 0 is only ever written by reset, so x0 never becomes busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= '0;
      is_var <= '0;
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (issue && (sb.id_rd_ip == REG_ADDR_W'(r))) begin
          busy[r] <= 1'b1;
          if (sb.id_lat_ip == '0) begin
            is_var[r] <= 1'b1;
            cnt[r]    <= '0;
          end else begin
            is_var[r] <= 1'b0;
            cnt[r]    <= sat_lat(sb.id_lat_ip);
          end
        end else if (busy[r] && !is_var[r]) begin
          if (cnt[r] != '0) cnt[r] <= cnt[r] - CNT_W'(1);
          if (cnt[r] <= CNT_W'(1)) busy[r] <= 1'b0;
        end else if (busy[r] && is_var[r] && sb.wb_valid_ip
                     && (sb.wb_rd_ip == REG_ADDR_W'(r))) begin
          busy[r]   <= 1'b0;
          is_var[r] <= 1'b0;
        end
      end
    end
  end

`ifdef SCOREBOARD_PERF_EN
  logic [31:0] perf_cnt;

  always_ff @(posedge clk) begin
    if (reset) perf_cnt <= '0;
    else if (sb.stall_op) perf_cnt <= sat_inc32(perf_cnt);
  end

  assign perf_stall_cnt_op = perf_cnt;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
// Self-checking bench for hazard_scoreboard: directed hazard scenarios plus a
// randomized run compared against a per-register "cycles remaining" model.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

  localparam int NUM_REGS = 32;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  // Model: rem[r] = 0 free, -1 waiting for writeback, >0 cycles until free.
  int   rem [NUM_REGS];

  hazard_scoreboard_if #(.NUM_REGS(32), .REG_ADDR_W(5), .CNT_W(4)) bus ();

`ifdef SCOREBOARD_PERF_EN
  logic [31:0] perf;
  hazard_scoreboard #(.NUM_REGS(32), .REG_ADDR_W(5), .MAX_LAT(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .sb(bus), .perf_stall_cnt_op(perf)
  );
`else
  hazard_scoreboard #(.NUM_REGS(32), .REG_ADDR_W(5), .MAX_LAT(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .sb(bus)
  );
`endif

  always #5 clk = ~clk;

  function automatic bit m_ready(input int r);
    if (r == 0) return 1'b1;
    if (rem[r] == 0 || rem[r] == 1) return 1'b1;
    return (rem[r] < 0) && bus.wb_valid_ip && (int'(bus.wb_rd_ip) == r);
  endfunction

  function automatic bit m_stall();
    int a, b, d;
    if (reset || !bus.id_valid_ip) return 1'b0;
    a = int'(bus.id_rs1_ip);
    b = int'(bus.id_rs2_ip);
    d = int'(bus.id_rd_ip);
    return (bus.id_rs1_use_ip && !m_ready(a))
        || (bus.id_rs2_use_ip && !m_ready(b))
        || (bus.id_rd_we_ip && d != 0 && rem[d] != 0);
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] v = '0;
    for (int r = 0; r < NUM_REGS; r++) v[r] = (rem[r] != 0);
    return v;
  endfunction

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_tick();
    bit iss;
    int d, l;
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) rem[r] = 0;
      return;
    end
    iss = bus.id_valid_ip && !m_stall() && bus.id_rd_we_ip && (bus.id_rd_ip != 0);
    d = int'(bus.id_rd_ip);
    l = int'(bus.id_lat_ip);
    for (int r = 0; r < NUM_REGS; r++) begin
      if (rem[r] > 0) rem[r] = rem[r] - 1;
      else if (rem[r] < 0 && bus.wb_valid_ip && int'(bus.wb_rd_ip) == r) rem[r] = 0;
    end
    if (iss) rem[d] = (l == 0) ? -1 : ((l > 8) ? 8 : l);
  endtask

  task automatic cycle();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int rs1, input bit u1, input int rs2,
                       input bit u2, input int rd, input bit we, input int lat);
    bus.id_valid_ip   = v;
    bus.id_rs1_ip     = 5'(rs1);
    bus.id_rs1_use_ip = u1;
    bus.id_rs2_ip     = 5'(rs2);
    bus.id_rs2_use_ip = u2;
    bus.id_rd_ip      = 5'(rd);
    bus.id_rd_we_ip   = we;
    bus.id_lat_ip     = 4'(lat);
    #1;
  endtask

  task automatic idle();
    bus.wb_valid_ip = 1'b0;
    bus.wb_rd_ip    = '0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    for (int r = 0; r < NUM_REGS; r++) rem[r] = 0;
    cycle();
    cycle();
    drive(1, 3, 1, 4, 1, 5, 1, 2);
    n_cmp++;
    if (bus.stall_op !== 1'b0) begin
      n_err++; $display("FAIL reset_stall: stall_op=%b expected 0", bus.stall_op);
    end
    n_cmp++;
    if (bus.busy_vec_op !== 32'h0) begin
      n_err++; $display("FAIL reset_busy: busy_vec_op=%h expected 0", bus.busy_vec_op);
    end
    reset = 1'b0;
    idle();
  endtask

  task automatic test_load_use();
    drive(1, 1, 1, 2, 1, 5, 1, 2);        // load x5, lat 2
    n_cmp++;
    if (bus.stall_op !== 1'b0) begin
      n_err++; $display("FAIL load_issue: stall_op=%b expected 0", bus.stall_op);
    end
    cycle();
    drive(1, 5, 1, 5, 1, 6, 1, 1);        // add x6,x5,x5
    n_cmp++;
    if (bus.stall_op !== 1'b1) begin
      n_err++; $display("FAIL load_use_stall: stall_op=%b expected 1", bus.stall_op);
    end
    cycle();
    n_cmp++;
    if (bus.stall_op !== 1'b0 || bus.busy_vec_op[5] !== 1'b1) begin
      n_err++; $display("FAIL load_use_release: stall_op=%b busy5=%b expected 0/1",
                        bus.stall_op, bus.busy_vec_op[5]);
    end
    cycle();
    idle();
    n_cmp++;
    if (bus.busy_vec_op !== 32'h0000_0040) begin
      n_err++; $display("FAIL load_busy_clear: busy_vec_op=%h expected 00000040", bus.busy_vec_op);
    end
    cycle();
    n_cmp++;
    if (bus.busy_vec_op !== 32'h0) begin
      n_err++; $display("FAIL alu_busy_clear: busy_vec_op=%h expected 0", bus.busy_vec_op);
    end
  endtask

  task automatic test_div_wb();
    drive(1, 1, 1, 0, 0, 7, 1, 0);        // div x7
    cycle();
    drive(1, 7, 1, 0, 0, 10, 1, 1);       // use x7
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (bus.stall_op !== 1'b1) begin
        n_err++; $display("FAIL div_hold[%0d]: stall_op=%b expected 1", i, bus.stall_op);
      end
      cycle();
    end
    bus.wb_valid_ip = 1'b1;
    bus.wb_rd_ip    = 5'd7;
    #1;
    n_cmp++;
    if (bus.stall_op !== 1'b0) begin
      n_err++; $display("FAIL div_wb_release: stall_op=%b expected 0", bus.stall_op);
    end
    cycle();
    idle();
    n_cmp++;
    if (bus.busy_vec_op !== 32'h0000_0400) begin
      n_err++; $display("FAIL div_busy_clear: busy_vec_op=%h expected 00000400", bus.busy_vec_op);
    end
    cycle();
  endtask

  task automatic test_x0();
    drive(1, 0, 1, 0, 1, 0, 1, 3);
    n_cmp++;
    if (bus.stall_op !== 1'b0) begin
      n_err++; $display("FAIL x0_stall: stall_op=%b expected 0", bus.stall_op);
    end
    cycle();
    drive(1, 0, 1, 0, 0, 0, 1, 0);
    cycle();
    idle();
    n_cmp++;
    if (bus.busy_vec_op !== 32'h0 || bus.stall_op !== 1'b0) begin
      n_err++; $display("FAIL x0_busy: busy_vec_op=%h stall_op=%b expected 0/0",
                        bus.busy_vec_op, bus.stall_op);
    end
  endtask

  task automatic test_waw();
    drive(1, 1, 1, 0, 0, 8, 1, 0);        // div x8
    cycle();
    drive(1, 1, 1, 0, 0, 8, 1, 1);        // addi x8,x1,1
    n_cmp++;
    if (bus.stall_op !== 1'b1) begin
      n_err++; $display("FAIL waw_stall: stall_op=%b expected 1", bus.stall_op);
    end
    cycle();
    bus.wb_valid_ip = 1'b1;
    bus.wb_rd_ip    = 5'd9;               // stray writeback, x9 not busy
    #1;
    cycle();
    bus.wb_valid_ip = 1'b0;
    #1;
    n_cmp++;
    if (bus.stall_op !== 1'b1 || bus.busy_vec_op !== 32'h0000_0100) begin
      n_err++; $display("FAIL waw_stray_wb: stall_op=%b busy_vec_op=%h expected 1/00000100",
                        bus.stall_op, bus.busy_vec_op);
    end
    bus.wb_valid_ip = 1'b1;
    bus.wb_rd_ip    = 5'd8;
    #1;
    n_cmp++;
    if (bus.stall_op !== 1'b1) begin
      n_err++; $display("FAIL waw_wb_cycle: stall_op=%b expected 1", bus.stall_op);
    end
    cycle();
    bus.wb_valid_ip = 1'b0;
    #1;
    n_cmp++;
    if (bus.stall_op !== 1'b0 || bus.busy_vec_op !== 32'h0) begin
      n_err++; $display("FAIL waw_release: stall_op=%b busy_vec_op=%h expected 0/0",
                        bus.stall_op, bus.busy_vec_op);
    end
    cycle();
    idle();
    cycle();
  endtask

  task automatic test_lat_clamp_reset();
    drive(1, 0, 0, 0, 0, 11, 1, 15);
    cycle();
    idle();
    for (int j = 1; j <= 8; j++) begin
      cycle();
      n_cmp++;
      if (bus.busy_vec_op[11] !== (j < 8)) begin
        n_err++; $display("FAIL clamp_cnt[%0d]: busy11=%b expected %0d", j,
                          bus.busy_vec_op[11], (j < 8));
      end
    end
    drive(1, 0, 0, 0, 0, 12, 1, 15);
    cycle();
    drive(1, 0, 0, 0, 0, 13, 1, 0);
    cycle();
    drive(1, 12, 1, 13, 1, 14, 1, 1);
    n_cmp++;
    if (bus.stall_op !== 1'b1) begin
      n_err++; $display("FAIL pre_reset_stall: stall_op=%b expected 1", bus.stall_op);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.stall_op !== 1'b0) begin
      n_err++; $display("FAIL reset_forces_stall: stall_op=%b expected 0", bus.stall_op);
    end
    cycle();
    reset = 1'b0;
    #1;
    n_cmp++;
    if (bus.busy_vec_op !== 32'h0 || bus.stall_op !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_clear: busy_vec_op=%h stall_op=%b expected 0/0",
                        bus.busy_vec_op, bus.stall_op);
    end
    idle();
    cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 79) == 0);
      bus.wb_valid_ip = ($urandom_range(0, 2) == 0);
      bus.wb_rd_ip    = 5'($urandom_range(0, 7));
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 3) != 0,
            ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15));
      n_cmp++;
      if (bus.stall_op !== m_stall()) begin
        n_err++; $display("FAIL rand_stall[%0d]: stall_op=%b expected %b", i, bus.stall_op, m_stall());
      end
      n_cmp++;
      if (bus.busy_vec_op !== m_busy()) begin
        n_err++; $display("FAIL rand_busy[%0d]: busy_vec_op=%h expected %h", i, bus.busy_vec_op, m_busy());
      end
      cycle();
    end
    reset = 1'b1;
    idle();
    cycle();
    reset = 1'b0;
    #1;
  endtask

`ifdef SCOREBOARD_PERF_EN
  task automatic test_perf();
    n_cmp++;
    if (perf !== 32'd0) begin
      n_err++; $display("FAIL perf_reset: perf=%h expected 0", perf);
    end
    drive(1, 0, 0, 0, 0, 7, 1, 0);
    cycle();
    drive(1, 7, 1, 0, 0, 10, 1, 1);
    for (int i = 0; i < 5; i++) cycle();
    idle();
    n_cmp++;
    if (perf !== 32'd5) begin
      n_err++; $display("FAIL perf_count: perf=%0d expected 5", perf);
    end
    dut.perf_cnt = 32'hFFFF_FFFD;
    drive(1, 7, 1, 0, 0, 10, 1, 1);
    for (int i = 0; i < 5; i++) cycle();
    idle();
    n_cmp++;
    if (perf !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL perf_saturate: perf=%h expected FFFFFFFF", perf);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_div_wb();
    test_x0();
    test_waw();
    test_lat_clamp_reset();
    test_random();
`ifdef SCOREBOARD_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
